// File: rtl/mem_arb_pkg.sv
// Shared types for the three-port memory arbiter: port identities, FSM states and access sizes.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    PORT_D = 2'd0,
    PORT_I = 2'd1,
    PORT_X = 2'd2
  } port_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  // Round-robin successor: D -> I -> X -> D.
  function automatic port_t next_port(input port_t p);
    case (p)
      PORT_D:  next_port = PORT_I;
      PORT_I:  next_port = PORT_X;
      default: next_port = PORT_D;
    endcase
  endfunction

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational grant picker. Fixed priority D > I > X by default; round-robin
// starting at ptr when MEM_ARB_RR_EN is defined.
module mem_arb_pick
  import mem_arb_pkg::*;
(
  input  logic [2:0] eligible,
  input  port_t      ptr,
  output logic       vld,
  output port_t      winner
);

  function automatic logic is_elig(input logic [2:0] e, input port_t p);
    case (p)
      PORT_D:  is_elig = e[0];
      PORT_I:  is_elig = e[1];
      PORT_X:  is_elig = e[2];
      default: is_elig = 1'b0;
    endcase
  endfunction

`ifdef MEM_ARB_RR_EN
  port_t p0, p1, p2;

  assign p0 = ptr;
  assign p1 = next_port(p0);
  assign p2 = next_port(p1);

  // Later assignments override earlier ones, so p0 (the pointer) wins ties.
  always_comb begin
    vld    = |eligible;
    winner = p2;
    if (is_elig(eligible, p1)) winner = p1;
    if (is_elig(eligible, p0)) winner = p0;
  end
`else
  logic unused_ptr;

  assign unused_ptr = ^ptr;

  always_comb begin
    vld    = |eligible;
    winner = PORT_X;
    if (is_elig(eligible, PORT_I)) winner = PORT_I;
    if (is_elig(eligible, PORT_D)) winner = PORT_D;
  end
`endif

endmodule

// File: rtl/mem_arbiter.sv
// Shares one req/ack backing memory port among data (D), fetch (I) and DMA (X).
// Define MEM_ARB_RR_EN for round-robin grant instead of fixed D > I > X priority.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          d_req,
  input  logic          i_req,
  input  logic          x_req,
  input  logic          d_we,
  input  logic          x_we,
  input  logic [1:0]    d_sz,
  input  logic [AW-1:0] d_addr,
  input  logic [AW-1:0] i_addr,
  input  logic [AW-1:0] x_addr,
  input  logic [DW-1:0] d_wdata,
  input  logic [DW-1:0] x_wdata,
  output logic          d_ack,
  output logic          i_ack,
  output logic          x_ack,
  output logic [DW-1:0] d_rdata,
  output logic [DW-1:0] i_rdata,
  output logic [DW-1:0] x_rdata,
  output logic          mem_req_o,
  output logic          mem_we_o,
  output logic [1:0]    mem_sz_o,
  output logic [AW-1:0] mem_addr_o,
  output logic [DW-1:0] mem_wdata_o,
  input  logic          mem_ack_i,
  input  logic [DW-1:0] mem_rdata_i
);

  state_t     state;
  port_t      owner;
  port_t      ptr;
  logic [2:0] eligible;
  logic       pick_vld;
  port_t      pick_port;

  // A port acked this cycle still shows req until next cycle; mask it.
  assign eligible = {x_req & ~x_ack, i_req & ~i_ack, d_req & ~d_ack};

  mem_arb_pick u_pick (
    .eligible (eligible),
    .ptr      (ptr),
    .vld      (pick_vld),
    .winner   (pick_port)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      owner       <= PORT_D;
      ptr         <= PORT_D;
      mem_req_o   <= 1'b0;
      mem_we_o    <= 1'b0;
      mem_sz_o    <= SZ_BYTE;
      mem_addr_o  <= '0;
      mem_wdata_o <= '0;
      d_ack       <= 1'b0;
      i_ack       <= 1'b0;
      x_ack       <= 1'b0;
      d_rdata     <= '0;
      i_rdata     <= '0;
      x_rdata     <= '0;
    end else begin
      d_ack <= 1'b0;
      i_ack <= 1'b0;
      x_ack <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (pick_vld) begin
            owner     <= pick_port;
            ptr       <= next_port(pick_port);
            mem_req_o <= 1'b1;
            state     <= ST_BUSY;
            case (pick_port)
              PORT_D: begin
                mem_we_o    <= d_we;
                mem_sz_o    <= d_sz;
                mem_addr_o  <= d_addr;
                mem_wdata_o <= d_wdata;
              end
              PORT_I: begin
                mem_we_o    <= 1'b0;
                mem_sz_o    <= SZ_WORD;
                mem_addr_o  <= i_addr;
                mem_wdata_o <= '0;
              end
              default: begin
                mem_we_o    <= x_we;
                mem_sz_o    <= SZ_WORD;
                mem_addr_o  <= x_addr;
                mem_wdata_o <= x_wdata;
              end
            endcase
          end
        end
        ST_BUSY: begin
          // Writes return zero so a stale bus value never reaches a requester.
          if (mem_ack_i) begin
            mem_req_o <= 1'b0;
            state     <= ST_IDLE;
            case (owner)
              PORT_D: begin
                d_ack   <= 1'b1;
                d_rdata <= mem_we_o ? '0 : mem_rdata_i;
              end
              PORT_I: begin
                i_ack   <= 1'b1;
                i_rdata <= mem_rdata_i;
              end
              default: begin
                x_ack   <= 1'b1;
                x_rdata <= mem_we_o ? '0 : mem_rdata_i;
              end
            endcase
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: directed stimulus with a behavioural backing memory.
module tb_mem_arbiter;
  import mem_arb_pkg::*;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam logic [31:0] RD_KEY = 32'h5A5A_0000;

  logic          clk = 1'b0;
  logic          rst;
  logic          d_req, i_req, x_req, d_we, x_we;
  logic [1:0]    d_sz;
  logic [AW-1:0] d_addr, i_addr, x_addr;
  logic [DW-1:0] d_wdata, x_wdata;
  logic          d_ack, i_ack, x_ack;
  logic [DW-1:0] d_rdata, i_rdata, x_rdata;
  logic          mem_req_o, mem_we_o;
  logic [1:0]    mem_sz_o;
  logic [AW-1:0] mem_addr_o;
  logic [DW-1:0] mem_wdata_o;
  logic          mem_ack_i;
  logic [DW-1:0] mem_rdata_i;

  mem_arbiter #(.AW(AW), .DW(DW)) dut (
    .clk(clk), .rst(rst),
    .d_req(d_req), .i_req(i_req), .x_req(x_req),
    .d_we(d_we), .x_we(x_we), .d_sz(d_sz),
    .d_addr(d_addr), .i_addr(i_addr), .x_addr(x_addr),
    .d_wdata(d_wdata), .x_wdata(x_wdata),
    .d_ack(d_ack), .i_ack(i_ack), .x_ack(x_ack),
    .d_rdata(d_rdata), .i_rdata(i_rdata), .x_rdata(x_rdata),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_sz_o(mem_sz_o),
    .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
    .mem_ack_i(mem_ack_i), .mem_rdata_i(mem_rdata_i)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    port_t       port;
    logic [31:0] rdata;
  } ack_exp_t;

  typedef struct packed {
    logic        we;
    logic [1:0]  sz;
    logic [31:0] addr;
    logic [31:0] wdata;
  } mem_exp_t;

  ack_exp_t ack_q[$];
  mem_exp_t mem_q[$];
  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int last_ack_cyc[3];
  int last_rise_cyc = -100;

  logic        mem_auto;
  int          mem_lat;
  logic        rd_ovr_en;
  logic [31:0] rd_ovr;
  logic        man_ack;
  logic [31:0] man_rdata;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_txn(input port_t p, input logic we, input logic [1:0] sz,
                          input logic [31:0] addr, input logic [31:0] wdata);
    mem_q.push_back('{we: we, sz: sz, addr: addr, wdata: wdata});
    ack_q.push_back('{port: p, rdata: we ? 32'h0 : (addr ^ RD_KEY)});
  endtask

  task automatic drain(input string name, input int budget);
    int n;
    n = 0;
    while ((ack_q.size() != 0 || mem_q.size() != 0) && n < budget) begin
      @(posedge clk);
      n++;
    end
    tick();
    if (ack_q.size() != 0 || mem_q.size() != 0) begin
      vectors++;
      miscompares++;
      $display("FAIL %s: timeout with %0d acks and %0d grants outstanding, expected 0",
               name, ack_q.size(), mem_q.size());
      ack_q.delete();
      mem_q.delete();
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
  endtask

  function automatic logic [31:0] base_of(input port_t p);
    case (p)
      PORT_D:  base_of = 32'h1000;
      PORT_I:  base_of = 32'h2000;
      default: base_of = 32'h3000;
    endcase
  endfunction

  // Backing memory: acks on the mem_lat-th cycle of mem_req_o, or follows man_ack.
  initial begin
    int cnt;
    cnt = 0;
    mem_ack_i = 1'b0;
    mem_rdata_i = '0;
    forever begin
      @(negedge clk);
      if (mem_auto && mem_req_o) begin
        cnt++;
        if (cnt >= mem_lat) begin
          mem_ack_i = 1'b1;
          mem_rdata_i = rd_ovr_en ? rd_ovr : (mem_addr_o ^ RD_KEY);
        end else begin
          mem_ack_i = 1'b0;
          mem_rdata_i = '0;
        end
      end else if (mem_auto) begin
        cnt = 0;
        mem_ack_i = 1'b0;
        mem_rdata_i = '0;
      end else begin
        cnt = 0;
        mem_ack_i = man_ack;
        mem_rdata_i = man_rdata;
      end
    end
  end

  // Monitor: pops expected grants and acks whenever the DUT presents them.
  initial begin
    logic        prev_req;
    logic [31:0] prev_addr;
    ack_exp_t    ea;
    mem_exp_t    em;
    port_t       p;
    logic [31:0] rd;
    int          n;
    prev_req = 1'b0;
    prev_addr = '0;
    forever begin
      @(negedge clk);
      n = int'(d_ack) + int'(i_ack) + int'(x_ack);
      if (n > 1) begin
        check("ack_onehot", n, 1);
      end else if (n == 1) begin
        if (d_ack) begin p = PORT_D; rd = d_rdata; end
        else if (i_ack) begin p = PORT_I; rd = i_rdata; end
        else begin p = PORT_X; rd = x_rdata; end
        last_ack_cyc[int'(p)] = cyc;
        if (ack_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_ack: port %0d acked, expected no ack", p);
        end else begin
          ea = ack_q.pop_front();
          check("ack_port", p, ea.port);
          check("ack_rdata", rd, ea.rdata);
        end
      end
      if (mem_req_o && !prev_req) begin
        last_rise_cyc = cyc;
        if (mem_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_grant: addr 0x%0h, expected no grant", mem_addr_o);
        end else begin
          em = mem_q.pop_front();
          check("grant_addr", mem_addr_o, em.addr);
          check("grant_ctl", {mem_we_o, mem_sz_o, mem_wdata_o}, {em.we, em.sz, em.wdata});
        end
      end else if (mem_req_o && prev_req) begin
        check("busy_addr_stable", mem_addr_o, prev_addr);
      end
      prev_req = mem_req_o;
      prev_addr = mem_addr_o;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0, a1, a2, acks;
    bit done;
    port_t ord[6];
    int cnt_p[3];
    port_t p;
    logic [31:0] a;

    last_ack_cyc = '{-100, -100, -100};
    rst = 1'b1;
    d_req = 0; i_req = 0; x_req = 0; d_we = 0; x_we = 0; d_sz = SZ_WORD;
    d_addr = 0; i_addr = 0; x_addr = 0; d_wdata = 0; x_wdata = 0;
    mem_auto = 1'b1; mem_lat = 1; rd_ovr_en = 1'b0; rd_ovr = 0;
    man_ack = 1'b0; man_rdata = 0;
    repeat (3) tick();

    check("rst_mem_req", mem_req_o, 0);
    check("rst_acks", {d_ack, i_ack, x_ack}, 0);
    check("rst_mem_addr", mem_addr_o, 0);
    check("rst_mem_ctl", {mem_we_o, mem_sz_o, mem_wdata_o}, 0);
    check("rst_rdata_di", {d_rdata, i_rdata}, 0);
    check("rst_rdata_x", x_rdata, 0);
    rst = 1'b0;
    tick();

    // D byte read at 0x103, memory acks in its first cycle.
    rd_ovr_en = 1'b1;
    rd_ovr = 32'hAABBCCDD;
    mem_q.push_back('{we: 1'b0, sz: SZ_BYTE, addr: 32'h103, wdata: 32'h0});
    ack_q.push_back('{port: PORT_D, rdata: 32'hAABBCCDD});
    d_req = 1; d_we = 0; d_sz = SZ_BYTE; d_addr = 32'h103; d_wdata = 0;
    tick();
    check("t1_mem_req", mem_req_o, 1);
    check("t1_mem_sz", mem_sz_o, SZ_BYTE);
    check("t1_mem_addr", mem_addr_o, 32'h103);
    tick();
    check("t1_d_ack", d_ack, 1);
    check("t1_d_rdata", d_rdata, 32'hAABBCCDD);
    d_req = 0;
    drain("t1_drain", 20);
    rd_ovr_en = 1'b0;

    // D write and X read together, memory latency 3.
    do_reset();
    mem_lat = 3;
    push_txn(PORT_D, 1'b1, SZ_WORD, 32'h200, 32'h11223344);
    mem_q.push_back('{we: 1'b0, sz: SZ_WORD, addr: 32'h300, wdata: 32'hCAFEF00D});
    ack_q.push_back('{port: PORT_X, rdata: 32'h300 ^ RD_KEY});
    d_req = 1; d_we = 1; d_sz = SZ_WORD; d_addr = 32'h200; d_wdata = 32'h11223344;
    x_req = 1; x_we = 0; x_addr = 32'h300; x_wdata = 32'hCAFEF00D;
    t0 = cyc;
    done = 0;
    for (int k = 0; k < 40 && !done; k++) begin
      tick();
      if (d_ack) d_req = 0;
      if (x_ack) begin x_req = 0; done = 1; end
    end
    if (!done) begin
      x_req = 0; d_req = 0;
      check("t2_x_ack_seen", 0, 1);
    end
    drain("t2_drain", 20);
    check("t2_d_latency", last_ack_cyc[0] - t0, 4);
    check("t2_x_req_rise", last_rise_cyc, last_ack_cyc[0] + 1);
    check("t2_x_ack_delay", last_ack_cyc[2], last_ack_cyc[0] + 4);

    // D, I, X held continuously for six transactions.
    do_reset();
    mem_lat = 1;
`ifdef MEM_ARB_RR_EN
    ord = '{PORT_D, PORT_I, PORT_X, PORT_D, PORT_I, PORT_X};
`else
    ord = '{PORT_D, PORT_I, PORT_D, PORT_I, PORT_D, PORT_I};
`endif
    cnt_p = '{0, 0, 0};
    for (int k = 0; k < 6; k++) begin
      p = ord[k];
      a = base_of(p) + 32'(4 * cnt_p[int'(p)]);
      case (p)
        PORT_D:  push_txn(p, 1'b0, SZ_HALF, a, 32'h0);
        PORT_I:  push_txn(p, 1'b0, SZ_WORD, a, 32'h0);
        default: push_txn(p, 1'b1, SZ_WORD, a, 32'hA000_0000 + 32'(cnt_p[2]));
      endcase
      cnt_p[int'(p)]++;
    end
    d_req = 1; d_we = 0; d_sz = SZ_HALF; d_addr = 32'h1000; d_wdata = 0;
    i_req = 1; i_addr = 32'h2000;
    x_req = 1; x_we = 1; x_addr = 32'h3000; x_wdata = 32'hA000_0000;
    acks = 0;
    for (int k = 0; k < 60 && acks < 6; k++) begin
      tick();
      if (d_ack) begin d_addr += 4; acks++; end
      if (i_ack) begin i_addr += 4; acks++; end
      if (x_ack) begin x_addr += 4; x_wdata += 1; acks++; end
    end
    d_req = 0; i_req = 0; x_req = 0;
    check("t3_ack_total", acks, 6);
    drain("t3_drain", 20);

    // I re-requests a new address in its own ack cycle.
    do_reset();
    push_txn(PORT_I, 1'b0, SZ_WORD, 32'h40, 32'h0);
    push_txn(PORT_I, 1'b0, SZ_WORD, 32'h44, 32'h0);
    i_req = 1; i_addr = 32'h40;
    a1 = -1; a2 = -1;
    for (int k = 0; k < 30 && a2 < 0; k++) begin
      tick();
      if (i_ack && a1 < 0) begin a1 = cyc; i_addr = 32'h44; end
      else if (i_ack) a2 = cyc;
    end
    i_req = 0;
    drain("t5_drain", 20);
    check("t5_regrant_cycle", last_rise_cyc, a1 + 2);
    check("t5_second_ack", a2, a1 + 3);

    // Spurious mem_ack_i in IDLE.
    mem_auto = 1'b0;
    man_rdata = 32'hFFFF_FFFF;
    man_ack = 1'b1;
    tick();
    tick();
    man_ack = 1'b0;
    tick();
    tick();
    check("t6_mem_req", mem_req_o, 0);
    check("t6_acks", {d_ack, i_ack, x_ack}, 0);
    check("t6_i_rdata_held", i_rdata, 32'h44 ^ RD_KEY);
    check("t6_d_rdata_held", d_rdata, 0);
    mem_auto = 1'b1;
    push_txn(PORT_D, 1'b0, SZ_WORD, 32'h500, 32'h0);
    d_req = 1; d_we = 0; d_sz = SZ_WORD; d_addr = 32'h500;
    t0 = cyc;
    tick();
    tick();
    check("t6_followup_ack", d_ack, 1);
    d_req = 0;
    drain("t6_drain", 20);
    check("t6_followup_latency", last_ack_cyc[0] - t0, 2);

    // Reset while I's transaction is outstanding; late memory ack must be dropped.
    mem_auto = 1'b0;
    man_ack = 1'b0;
    mem_q.push_back('{we: 1'b0, sz: SZ_WORD, addr: 32'h80, wdata: 32'h0});
    i_req = 1; i_addr = 32'h80;
    tick();
    check("t4_busy_req", mem_req_o, 1);
    repeat (5) tick();
    rst = 1'b1;
    i_req = 0;
    tick();
    check("t4_rst_req", mem_req_o, 0);
    check("t4_rst_i_ack", i_ack, 0);
    rst = 1'b0;
    tick();
    tick();
    man_rdata = 32'h1234_5678;
    man_ack = 1'b1;
    tick();
    man_ack = 1'b0;
    repeat (3) tick();
    check("t4_late_req", mem_req_o, 0);
    check("t4_late_i_rdata", i_rdata, 0);
    drain("t4_drain", 10);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
